// File: rtl/msrv32_ahb_data_responder_if.sv
// AHB-lite data-port bundle between the core (master) and the data-memory responder (slave).
interface msrv32_ahb_data_responder_if;
  logic [31:0] ms_riscv32_mp_dmaddr_in;
  logic [31:0] ms_riscv32_mp_dmdata_in;
  logic        ms_riscv32_mp_dmwr_req_in;
  logic [3:0]  ms_riscv32_mp_dmwr_mask_in;
  logic [1:0]  ms_riscv32_mp_data_htrans_in;
  logic [31:0] ms_riscv32_mp_data_out;
  logic        ms_riscv32_mp_data_hready_out;
  logic        ms_riscv32_mp_hresp_out;

  modport master (
    output ms_riscv32_mp_dmaddr_in,
    output ms_riscv32_mp_dmdata_in,
    output ms_riscv32_mp_dmwr_req_in,
    output ms_riscv32_mp_dmwr_mask_in,
    output ms_riscv32_mp_data_htrans_in,
    input  ms_riscv32_mp_data_out,
    input  ms_riscv32_mp_data_hready_out,
    input  ms_riscv32_mp_hresp_out
  );

  modport slave (
    input  ms_riscv32_mp_dmaddr_in,
    input  ms_riscv32_mp_dmdata_in,
    input  ms_riscv32_mp_dmwr_req_in,
    input  ms_riscv32_mp_dmwr_mask_in,
    input  ms_riscv32_mp_data_htrans_in,
    output ms_riscv32_mp_data_out,
    output ms_riscv32_mp_data_hready_out,
    output ms_riscv32_mp_hresp_out
  );
endinterface

// File: rtl/msrv32_ahb_data_responder.sv
// AHB-lite data memory with configurable wait states, two-cycle ERROR for
// out-of-range addresses and write-to-read forwarding on back-to-back transfers.
module msrv32_ahb_data_responder #(
  parameter int unsigned DEPTH       = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic                              ms_riscv32_mp_clk_in,
  input  logic                              ms_riscv32_mp_rst_in,
  msrv32_ahb_data_responder_if.slave        bus
);
  localparam int unsigned AW        = $clog2(DEPTH);
  localparam logic [32:0] LIMIT     = 33'(DEPTH) << 2;
  localparam logic [3:0]  WAIT_INIT = (WAIT_STATES > 32'd0) ? 4'(WAIT_STATES - 32'd1) : 4'd0;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WAIT = 3'd1,
    S_DATA = 3'd2,
    S_ERR1 = 3'd3,
    S_ERR2 = 3'd4
  } state_e;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  be);
    logic [31:0] res;
    for (int b = 0; b < 4; b++) begin
      res[8*b +: 8] = be[b] ? new_w[8*b +: 8] : old_w[8*b +: 8];
    end
    return res;
  endfunction

  state_e        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [AW-1:0] idx_q, idx_d;
  logic          wr_q, wr_d;
  logic [3:0]    mask_q, mask_d;
  logic [31:0]   data_q, data_d;
  logic          hready_q, hready_d;
  logic          hresp_q, hresp_d;
  logic [31:0]   mem_q [DEPTH];

  logic [32:0]   off_s;
  logic          in_range_s;
  logic [AW-1:0] bus_idx_s;
  logic          accept_s;
  logic          fwd_hit_s;
  logic [31:0]   rd_word_s;

  // A negative offset wraps to a value with bit 32 set, so one compare covers both bounds.
  assign off_s      = {1'b0, bus.ms_riscv32_mp_dmaddr_in} - {1'b0, BASE_ADDR};
  assign in_range_s = (off_s < LIMIT);
  assign bus_idx_s  = off_s[AW+1:2];
  assign accept_s   = hready_q && ((bus.ms_riscv32_mp_data_htrans_in == 2'b10) ||
                                   (bus.ms_riscv32_mp_data_htrans_in == 2'b11));
  assign fwd_hit_s  = (state_q == S_DATA) && wr_q && (idx_q == bus_idx_s);
  assign rd_word_s  = fwd_hit_s ? merge_bytes(mem_q[bus_idx_s], bus.ms_riscv32_mp_dmdata_in, mask_q)
                                : mem_q[bus_idx_s];

  assign bus.ms_riscv32_mp_data_out        = data_q;
  assign bus.ms_riscv32_mp_data_hready_out = hready_q;
  assign bus.ms_riscv32_mp_hresp_out       = hresp_q;

  // Next-state, captured address phase and read data selection.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    wr_d    = wr_q;
    mask_d  = mask_q;
    data_d  = data_q;
    case (state_q)
      S_IDLE, S_DATA, S_ERR2: begin
        if (accept_s) begin
          idx_d  = bus_idx_s;
          wr_d   = bus.ms_riscv32_mp_dmwr_req_in;
          mask_d = bus.ms_riscv32_mp_dmwr_mask_in;
          if (!in_range_s) begin
            state_d = S_ERR1;
            data_d  = bus.ms_riscv32_mp_dmwr_req_in ? data_q : 32'd0;
          end else if (WAIT_STATES == 32'd0) begin
            state_d = S_DATA;
            data_d  = bus.ms_riscv32_mp_dmwr_req_in ? data_q : rd_word_s;
          end else begin
            state_d = S_WAIT;
            cnt_d   = WAIT_INIT;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = S_DATA;
          data_d  = wr_q ? data_q : mem_q[idx_q];
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_ERR1:  state_d = S_ERR2;
      default: state_d = S_IDLE;
    endcase

    case (state_d)
      S_WAIT:  begin hready_d = 1'b0; hresp_d = 1'b0; end
      S_ERR1:  begin hready_d = 1'b0; hresp_d = 1'b1; end
      S_ERR2:  begin hready_d = 1'b1; hresp_d = 1'b1; end
      default: begin hready_d = 1'b1; hresp_d = 1'b0; end
    endcase
  end

  // Control and output registers.
  always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_in) begin
    if (!ms_riscv32_mp_rst_in) begin
      state_q  <= S_IDLE;
      cnt_q    <= 4'd0;
      idx_q    <= '0;
      wr_q     <= 1'b0;
      mask_q   <= 4'd0;
      data_q   <= 32'd0;
      hready_q <= 1'b1;
      hresp_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      wr_q     <= wr_d;
      mask_q   <= mask_d;
      data_q   <= data_d;
      hready_q <= hready_d;
      hresp_q  <= hresp_d;
    end
  end

  // Writes commit only on the final OKAY cycle, so an aborted write never lands.
  always_ff @(posedge ms_riscv32_mp_clk_in) begin
    if ((state_q == S_DATA) && wr_q) begin
      for (int b = 0; b < 4; b++) begin
        if (mask_q[b]) begin
          mem_q[idx_q][8*b +: 8] <= bus.ms_riscv32_mp_dmdata_in[8*b +: 8];
        end
      end
    end
  end
endmodule

// File: tb/tb_msrv32_ahb_data_responder.sv
// Randomized bench: two responders (0 and 3 wait states) checked cycle by cycle
// against a transaction-level memory model.
module tb_msrv32_ahb_data_responder;
  localparam int          DEPTH = 64;
  localparam logic [31:0] BASE0 = 32'h0000_0000;
  localparam logic [31:0] BASE1 = 32'h0000_1000;

  typedef struct {
    bit          idle;
    bit          wr;
    logic [1:0]  htrans;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  mask;
    bit          chk;
    logic [31:0] exp;
    bit          err;
    int          idx;
  } txn_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] addr_r  [2];
  logic [31:0] wdata_r [2];
  logic        wr_r    [2];
  logic [3:0]  mask_r  [2];
  logic [1:0]  htrans_r[2];

  logic [31:0] mdl_mem [2][DEPTH];
  logic [31:0] mdl_last[2];
  txn_t        dir_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;

  msrv32_ahb_data_responder_if bus0();
  msrv32_ahb_data_responder_if bus1();

  assign bus0.ms_riscv32_mp_dmaddr_in      = addr_r[0];
  assign bus0.ms_riscv32_mp_dmdata_in      = wdata_r[0];
  assign bus0.ms_riscv32_mp_dmwr_req_in    = wr_r[0];
  assign bus0.ms_riscv32_mp_dmwr_mask_in   = mask_r[0];
  assign bus0.ms_riscv32_mp_data_htrans_in = htrans_r[0];
  assign bus1.ms_riscv32_mp_dmaddr_in      = addr_r[1];
  assign bus1.ms_riscv32_mp_dmdata_in      = wdata_r[1];
  assign bus1.ms_riscv32_mp_dmwr_req_in    = wr_r[1];
  assign bus1.ms_riscv32_mp_dmwr_mask_in   = mask_r[1];
  assign bus1.ms_riscv32_mp_data_htrans_in = htrans_r[1];

  msrv32_ahb_data_responder #(.DEPTH(DEPTH), .BASE_ADDR(BASE0), .WAIT_STATES(0)) u_dut0 (
    .ms_riscv32_mp_clk_in (clk),
    .ms_riscv32_mp_rst_in (rst_n),
    .bus                  (bus0)
  );

  msrv32_ahb_data_responder #(.DEPTH(DEPTH), .BASE_ADDR(BASE1), .WAIT_STATES(3)) u_dut1 (
    .ms_riscv32_mp_clk_in (clk),
    .ms_riscv32_mp_rst_in (rst_n),
    .bus                  (bus1)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int ws(input int s);
    return (s == 0) ? 0 : 3;
  endfunction

  function automatic logic [31:0] base(input int s);
    return (s == 0) ? BASE0 : BASE1;
  endfunction

  function automatic logic get_rdy(input int s);
    return (s == 0) ? bus0.ms_riscv32_mp_data_hready_out : bus1.ms_riscv32_mp_data_hready_out;
  endfunction

  function automatic logic get_rsp(input int s);
    return (s == 0) ? bus0.ms_riscv32_mp_hresp_out : bus1.ms_riscv32_mp_hresp_out;
  endfunction

  function automatic logic [31:0] get_dat(input int s);
    return (s == 0) ? bus0.ms_riscv32_mp_data_out : bus1.ms_riscv32_mp_data_out;
  endfunction

  function automatic txn_t idle_txn();
    txn_t t;
    t.idle = 1'b1; t.wr = 1'b0; t.htrans = 2'(($urandom % 2));
    t.addr = $urandom; t.wdata = $urandom; t.mask = 4'($urandom);
    t.chk = 1'b0; t.exp = 32'd0; t.err = 1'b0; t.idx = 0;
    return t;
  endfunction

  function automatic txn_t rand_txn(input int s);
    txn_t t;
    int   sel;
    t = idle_txn();
    if ($urandom_range(0, 4) != 0) begin
      t.idle   = 1'b0;
      t.htrans = 2'($urandom_range(2, 3));
      t.wr     = 1'($urandom);
      sel      = $urandom_range(0, 9);
      if (sel == 0)      t.addr = base(s) + 32'(4 * DEPTH) + 32'($urandom_range(0, 63));
      else if (sel == 1) t.addr = base(s) - 32'd4 - 32'($urandom_range(0, 63));
      else               t.addr = base(s) + 32'(4 * $urandom_range(0, DEPTH - 1)) + 32'($urandom_range(0, 3));
    end
    return t;
  endfunction

  function automatic txn_t classify(input int s, input txn_t t_in);
    txn_t   t;
    longint off;
    t   = t_in;
    off = longint'({32'd0, t.addr}) - longint'({32'd0, base(s)});
    t.err = (off < 0) || (off >= 4 * DEPTH);
    t.idx = t.err ? 0 : int'(off / 4);
    return t;
  endfunction

  task automatic push(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] mask, input bit chk, input logic [31:0] exp);
    txn_t t;
    t = idle_txn();
    t.idle = 1'b0; t.htrans = 2'b10; t.wr = wr; t.addr = addr;
    t.wdata = wdata; t.mask = mask; t.chk = chk; t.exp = exp;
    dir_q.push_back(t);
  endtask

  // Drives queued then random transfers on responder s; checks every cycle against the model.
  task automatic run(input int s, input int n_cycles, input bit rnd);
    txn_t cur, nxt;
    bit   busy, last_c;
    int   rem, cyc;
    busy = 1'b0; rem = 0; cyc = 0;
    cur  = idle_txn();
    while ((cyc < n_cycles || busy || dir_q.size() != 0) && cyc < 5000) begin
      @(negedge clk);
      cyc++;
      last_c = !busy || (rem == 1);
      check_val("hready", 32'(get_rdy(s)), 32'(last_c));
      check_val("hresp", 32'(get_rsp(s)), 32'(busy && cur.err));
      if (last_c) begin
        if (busy && !cur.wr) begin
          mdl_last[s] = cur.err ? 32'd0 : mdl_mem[s][cur.idx];
          if (cur.chk) check_val("rd_exp", get_dat(s), cur.exp);
        end
        check_val("rd_data", get_dat(s), mdl_last[s]);
        if (busy && cur.wr && !cur.err) begin
          for (int b = 0; b < 4; b++) begin
            if (cur.mask[b]) mdl_mem[s][cur.idx][8*b +: 8] = cur.wdata[8*b +: 8];
          end
          wdata_r[s] = cur.wdata;
        end else begin
          wdata_r[s] = $urandom;
        end
        if (dir_q.size() != 0)          nxt = dir_q.pop_front();
        else if (rnd && cyc < n_cycles) nxt = rand_txn(s);
        else                            nxt = idle_txn();
        nxt = classify(s, nxt);
        htrans_r[s] = nxt.htrans; addr_r[s] = nxt.addr;
        wr_r[s]     = nxt.wr;     mask_r[s] = nxt.mask;
        cur  = nxt;
        busy = !nxt.idle;
        rem  = nxt.err ? 2 : ws(s) + 1;
      end else begin
        rem--;
        htrans_r[s] = 2'($urandom); addr_r[s] = $urandom;
        wr_r[s]     = 1'($urandom); mask_r[s] = 4'($urandom);
        wdata_r[s]  = $urandom;
      end
    end
    check_val("run_done", 32'(busy), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    for (int s = 0; s < 2; s++) begin
      addr_r[s] = 32'd0; wdata_r[s] = 32'd0; wr_r[s] = 1'b0;
      mask_r[s] = 4'd0;  htrans_r[s] = 2'b00; mdl_last[s] = 32'd0;
    end
    repeat (3) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      check_val("rst_hready", 32'(get_rdy(s)), 32'd1);
      check_val("rst_hresp", 32'(get_rsp(s)), 32'd0);
      check_val("rst_data", get_dat(s), 32'd0);
    end
    rst_n = 1'b1;
    run(0, 5, 1'b0);
    run(1, 5, 1'b0);

    for (int s = 0; s < 2; s++) begin
      for (int w = 0; w < DEPTH; w++) push(1'b1, base(s) + 32'(4 * w), $urandom, 4'hF, 1'b0, 32'd0);
      run(s, 1, 1'b0);
    end

    push(1'b1, BASE0 + 32'h10, 32'hDEAD_BEEF, 4'hF, 1'b0, 32'd0);
    push(1'b0, BASE0 + 32'h10, 32'd0, 4'h0, 1'b1, 32'hDEAD_BEEF);
    push(1'b1, BASE0 + 32'h20, 32'h1122_3344, 4'hF, 1'b0, 32'd0);
    push(1'b1, BASE0 + 32'h20, 32'hAABB_CCDD, 4'b0101, 1'b0, 32'd0);
    push(1'b0, BASE0 + 32'h20, 32'd0, 4'h0, 1'b1, 32'h11BB_33DD);
    push(1'b1, BASE0 + 32'h24, 32'h0BAD_F00D, 4'h0, 1'b0, 32'd0);
    push(1'b0, BASE0 + 32'h24, 32'd0, 4'h0, 1'b0, 32'd0);
    run(0, 2, 1'b0);

    push(1'b1, BASE1 + 32'h04, 32'hCAFE_0004, 4'hF, 1'b0, 32'd0);
    push(1'b0, BASE1 + 32'h04, 32'd0, 4'h0, 1'b1, 32'hCAFE_0004);
    run(1, 2, 1'b0);

    for (int s = 0; s < 2; s++) begin
      push(1'b0, base(s) + 32'(4 * DEPTH), 32'd0, 4'h0, 1'b1, 32'd0);
      push(1'b1, base(s) + 32'(4 * DEPTH), 32'hFFFF_FFFF, 4'hF, 1'b0, 32'd0);
      push(1'b1, base(s) - 32'd4, 32'hFFFF_FFFF, 4'hF, 1'b0, 32'd0);
      for (int w = 0; w < DEPTH; w++) push(1'b0, base(s) + 32'(4 * w), 32'd0, 4'h0, 1'b0, 32'd0);
      run(s, 2, 1'b0);
    end

    run(0, 800, 1'b1);
    run(1, 800, 1'b1);

    push(1'b1, BASE1 + 32'h08, 32'h5555_5555, 4'hF, 1'b0, 32'd0);
    run(1, 1, 1'b0);
    @(negedge clk);
    addr_r[1] = BASE1 + 32'h08; wr_r[1] = 1'b1; mask_r[1] = 4'hF;
    htrans_r[1] = 2'b10; wdata_r[1] = 32'hFFFF_FFFF;
    @(negedge clk);
    htrans_r[1] = 2'b00;
    check_val("mid_wait_hready", 32'(get_rdy(1)), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check_val("mid_rst_hready", 32'(get_rdy(1)), 32'd1);
    check_val("mid_rst_hresp", 32'(get_rsp(1)), 32'd0);
    check_val("mid_rst_data", get_dat(1), 32'd0);
    check_val("mid_rst_data0", get_dat(0), 32'd0);
    mdl_last[0] = 32'd0;
    mdl_last[1] = 32'd0;
    @(negedge clk);
    rst_n = 1'b1;
    push(1'b0, BASE1 + 32'h08, 32'd0, 4'h0, 1'b1, 32'h5555_5555);
    run(1, 2, 1'b0);
    run(0, 3, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/msrv32_ahb_data_responder.md
Name: msrv32_ahb_data_responder

Overview:
- AHB-lite data-memory responder at the far end of the core's data port.
- Consumes the core's data address, write data, write request, byte mask and htrans.
- Returns read data, hready and hresp.
- Used as the bench/FPGA data memory behind the top wrapper, with configurable wait states and an ERROR response for out-of-range accesses.

Parameters:
- DEPTH, 1024, memory size in 32-bit words (power of two, 16..65536).
- BASE_ADDR, 32'h0000_0000, byte address of word 0 (word aligned).
- WAIT_STATES, 0, wait cycles inserted per OKAY transfer (0..15).

Ports:
- ms_riscv32_mp_clk_in  input  1  system clock; all state on rising edge.
- ms_riscv32_mp_rst_in  input  1  asynchronous, active-low reset.
- ms_riscv32_mp_dmaddr_in  input  32  byte address from core (dmaddr_out).
- ms_riscv32_mp_dmdata_in  input  32  write data from core (dmdata_out).
- ms_riscv32_mp_dmwr_req_in  input  1  1 = write, 0 = read; address-phase signal.
- ms_riscv32_mp_dmwr_mask_in  input  4  byte enables; bit i covers data[8i+7:8i]; address-phase signal.
- ms_riscv32_mp_data_htrans_in  input  2  0 IDLE, 1 BUSY, 2 NONSEQ, 3 SEQ.
- ms_riscv32_mp_data_out  output  32  read data to core (data_in).
- ms_riscv32_mp_data_hready_out  output  1  transfer done / ready for next address.
- ms_riscv32_mp_hresp_out  output  1  0 OKAY, 1 ERROR.

Behaviour:
- Reset (async, rst_in = 0): hready_out = 1, hresp_out = 0, data_out = 0, FSM in S_IDLE, wait counter 0, pending write discarded. Memory array is not reset. Reset asserted mid-transfer aborts that transfer immediately; no write commits.
- Address phase: sampled on a rising edge where hready_out = 1 and htrans[1] = 1 (NONSEQ/SEQ). Registers addr, wr_req, mask and a range flag.
- IDLE/BUSY address phases are not transfers and produce no data phase; next state is S_IDLE (OKAY, zero wait).
- In range: BASE_ADDR <= addr < BASE_ADDR + 4*DEPTH. Word index = (addr - BASE_ADDR) >> 2; addr[1:0] ignored.
- FSM states:
  - S_IDLE: hready = 1, hresp = 0.
  - S_WAIT: hready = 0, hresp = 0; counter decrements each cycle.
  - S_DATA: hready = 1, hresp = 0; final OKAY cycle.
  - S_ERR1: hready = 0, hresp = 1.
  - S_ERR2: hready = 1, hresp = 1.
- Transitions on a sampled transfer, from S_IDLE, S_DATA or S_ERR2:
  - out of range -> S_ERR1;
  - WAIT_STATES = 0 -> S_DATA;
  - otherwise -> S_WAIT with counter = WAIT_STATES - 1.
- Other transitions: S_WAIT -> S_DATA when counter = 0. S_ERR1 -> S_ERR2. S_DATA / S_ERR2 / S_IDLE with no new transfer -> S_IDLE.
- Latency: an OKAY transfer completes WAIT_STATES + 1 cycles after its address-phase edge. An ERROR always takes exactly 2 cycles: hresp high in both, hready low then high.
- Read: data_out holds the addressed word throughout S_DATA. data_out holds its last value in all other states; it is 0 for ERROR reads.
- Write: dmdata_in is sampled on the S_DATA edge (hready = 1). Only bytes with mask bit = 1 update; mask 4'b0000 writes nothing but still completes OKAY. Out-of-range writes never modify memory.
- Pipelining: the next address phase overlaps the current S_DATA/S_ERR2 cycle, giving back-to-back transfers with no idle cycle.
- RAW forwarding: a read whose address phase coincides with the commit edge of a write to the same word must return the merged post-write bytes.
- htrans is sampled only while hready_out = 1; changes during wait cycles are ignored.

Test Plan:
- Reset: hold rst_in = 0, then release -> hready = 1, hresp = 0, data_out = 32'h0; an IDLE htrans for 5 cycles leaves outputs unchanged.
- WAIT_STATES = 0: write 32'hDEAD_BEEF to 0x10 (mask 4'hF), then read 0x10 back-to-back -> hready never low; read data 32'hDEAD_BEEF on the cycle after the read address edge (forwarding path).
- Byte mask: word 0x20 = 32'h1122_3344, write 32'hAABB_CCDD with mask 4'b0101 -> read returns 32'h11BB_33DD.
- WAIT_STATES = 3: read 0x04 -> hready low for exactly 3 cycles, then high with correct data on the 4th cycle after the address edge.
- Error: read BASE_ADDR + 4*DEPTH -> hresp = 1 for 2 cycles with hready 0 then 1, data_out = 0. Write to the same address -> memory unchanged, verified by read-back of all words touched.
- Reset mid-write: assert rst_in during S_WAIT of a write to 0x08 holding 32'h5555_5555 with data 32'hFFFF_FFFF -> outputs return to reset values at once; a later read of 0x08 returns 32'h5555_5555.
